// File: rtl/id_decode_issue_if.sv
// ============================================================================
// Module : id_decode_issue_if
// Brief  : IF/ID valid/ready handshake carrying the instruction word and its PC.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_decode_issue_if #(
  parameter int WordSize = 32
) ();
  logic                instr_valid;
  logic [31:0]         instr;
  logic [WordSize-1:0] pc_in;
  logic                instr_ready;

  modport master (output instr_valid, output instr, output pc_in, input instr_ready);
  modport slave  (input instr_valid, input instr, input pc_in, output instr_ready);
endinterface

`default_nettype wire

// File: rtl/id_decode_issue.sv
// ============================================================================
// Module : id_decode_issue
// Brief  : RV32I decode/issue stage feeding ID/EX, with load-use interlock and
//          EX flush. Build option ID_BTFN_PREDICT_EN enables backward-taken
//          static prediction for conditional branches.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decode_issue #(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  id_decode_issue_if.slave    ifid,
  input  logic                flush,
  input  logic [WordSize-1:0] rs1d,
  output logic [4:0]          rs1n,
  output logic [4:0]          rs2n,
  output logic [1:0]          a_sel,
  output logic [1:0]          b_sel,
  output logic [WordSize-1:0] imm,
  output logic [WordSize-1:0] branch_addr,
  output logic                branch_taken,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] pc,
  output logic                mem_read,
  output logic                illegal,
  output logic [15:0]         stall_count
);

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ld_v, w_ld_v_nxt;
  logic [4:0]          r_ld_rd, w_ld_rd_nxt;
  logic [15:0]         r_stall_count;
  logic                w_stall_inc;
  logic                w_ready;
  logic                w_issue;
  logic                w_drive;
  logic                w_hazard;

  logic [31:0]         w_instr;
  logic [6:0]          w_opcode;
  logic [4:0]          w_rd;
  logic [WordSize-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [WordSize-1:0] w_jalr_sum;
  logic                w_br_predict;

  logic [1:0]          w_dec_a, w_dec_b;
  logic [WordSize-1:0] w_dec_imm, w_dec_ba;
  logic                w_dec_taken, w_dec_mr, w_dec_ill;
  logic [4:0]          w_dec_rd;
  logic                w_use1, w_use2;

  assign w_instr  = ifid.instr;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign rs1n     = w_instr[19:15];
  assign rs2n     = w_instr[24:20];
  assign pc       = ifid.pc_in;

  assign w_imm_i = {{(WordSize-12){w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{(WordSize-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{(WordSize-13){w_instr[31]}}, w_instr[31], w_instr[7],
                    w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_j = {{(WordSize-21){w_instr[31]}}, w_instr[31], w_instr[19:12],
                    w_instr[20], w_instr[30:21], 1'b0};
  assign w_imm_u = {{(WordSize-20){1'b0}}, w_instr[31:12]};
  assign w_jalr_sum = rs1d + w_imm_i;

`ifdef ID_BTFN_PREDICT_EN
  // Sign of the B-immediate: backward branches predicted taken.
  assign w_br_predict = w_instr[31];
`else
  assign w_br_predict = 1'b0;
`endif

  always_comb begin
    w_dec_a     = 2'd0;
    w_dec_b     = 2'd0;
    w_dec_imm   = '0;
    w_dec_ba    = '0;
    w_dec_taken = 1'b0;
    w_dec_rd    = 5'd0;
    w_dec_mr    = 1'b0;
    w_dec_ill   = 1'b0;
    w_use1      = 1'b0;
    w_use2      = 1'b0;
    case (w_opcode)
      c_op_op: begin
        w_dec_rd = w_rd; w_use1 = 1'b1; w_use2 = 1'b1;
      end
      c_op_imm, c_op_load: begin
        w_dec_b = 2'd1; w_dec_imm = w_imm_i; w_dec_rd = w_rd; w_use1 = 1'b1;
        w_dec_mr = (w_opcode == c_op_load);
      end
      c_op_store: begin
        w_dec_b = 2'd1; w_dec_imm = w_imm_s; w_use1 = 1'b1; w_use2 = 1'b1;
      end
      c_op_lui: begin
        w_dec_a = 2'd3; w_dec_b = 2'd3; w_dec_imm = w_imm_u; w_dec_rd = w_rd;
      end
      c_op_auipc: begin
        w_dec_a = 2'd1; w_dec_b = 2'd3; w_dec_imm = w_imm_u; w_dec_rd = w_rd;
      end
      c_op_jal: begin
        w_dec_a = 2'd1; w_dec_b = 2'd2; w_dec_imm = w_imm_j; w_dec_rd = w_rd;
        w_dec_ba = ifid.pc_in + w_imm_j; w_dec_taken = 1'b1;
      end
      c_op_jalr: begin
        w_dec_a = 2'd1; w_dec_b = 2'd2; w_dec_imm = w_imm_i; w_dec_rd = w_rd;
        w_dec_ba = w_jalr_sum & {{(WordSize-1){1'b1}}, 1'b0};
        w_dec_taken = 1'b1; w_use1 = 1'b1;
      end
      c_op_branch: begin
        w_dec_imm = w_imm_b; w_dec_ba = ifid.pc_in + w_imm_b;
        w_dec_taken = w_br_predict; w_use1 = 1'b1; w_use2 = 1'b1;
      end
      default: begin
        // Unknown opcode is consumed as a bubble that flags illegal.
        w_dec_a = 2'd3; w_dec_b = 2'd1; w_dec_ill = 1'b1;
      end
    endcase
  end

  assign w_hazard = ifid.instr_valid & r_ld_v & (r_ld_rd != 5'd0) &
                    ((w_use1 & (rs1n == r_ld_rd)) | (w_use2 & (rs2n == r_ld_rd)));

  always_comb begin
    w_state_nxt = r_state;
    w_ld_v_nxt  = r_ld_v;
    w_ld_rd_nxt = r_ld_rd;
    w_stall_inc = 1'b0;
    w_ready     = 1'b0;
    w_issue     = 1'b0;
    if (flush || !ifid.instr_valid) begin
      w_ready     = 1'b1;
      w_ld_v_nxt  = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN && w_hazard) begin
      w_ld_v_nxt  = 1'b0;
      w_stall_inc = 1'b1;
      w_state_nxt = ST_STALL;
    end else begin
      w_ready     = 1'b1;
      w_issue     = 1'b1;
      w_ld_v_nxt  = w_dec_mr & (w_rd != 5'd0);
      w_ld_rd_nxt = w_rd;
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_RUN;
      r_ld_v        <= 1'b0;
      r_ld_rd       <= 5'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ld_v  <= w_ld_v_nxt;
      r_ld_rd <= w_ld_rd_nxt;
      if (w_stall_inc && r_stall_count != 16'hFFFF) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  // While reset is asserted every ID/EX input reads as a bubble.
  assign w_drive          = w_issue & rstn;
  assign ifid.instr_ready = w_ready & rstn;
  assign a_sel            = w_drive ? w_dec_a   : 2'd3;
  assign b_sel            = w_drive ? w_dec_b   : 2'd1;
  assign imm              = w_drive ? w_dec_imm : '0;
  assign branch_addr      = w_drive ? w_dec_ba  : '0;
  assign rdn              = w_drive ? w_dec_rd  : 5'd0;
  assign branch_taken     = w_drive & w_dec_taken;
  assign mem_read         = w_drive & w_dec_mr;
  assign illegal          = w_drive & w_dec_ill;
  assign stall_count      = r_stall_count;

endmodule

`default_nettype wire

// File: doc/id_decode_issue.md
Name: id_decode_issue

Overview:
- Decode/issue stage that produces every control and operand-select input consumed by the ID/EX pipeline register.
- Takes the fetched RV32I instruction and PC from IF/ID with a valid/ready handshake and decodes register numbers, immediates and select codes.
- Computes the branch/jump target and static prediction.
- Interlocks load-use hazards with a one-cycle bubble and kills issue on a flush from EX.

Parameters:
- WordSize, 32, datapath/PC width in bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- instr_valid  in  1  IF/ID holds a valid instruction
- instr  in  32  instruction word
- pc_in  in  WordSize  PC of instr
- flush  in  1  EX redirect; kill current issue
- rs1d  in  WordSize  register-file rs1 data (JALR target)
- instr_ready  out  1  instruction consumed this cycle
- rs1n  out  5  register-file read address 1 (instr[19:15])
- rs2n  out  5  register-file read address 2 (instr[24:20])
- a_sel  out  2  to ID/EX: 0 rs1d, 1 pc, 3 zero
- b_sel  out  2  to ID/EX: 0 rs2d, 1 imm, 2 constant 4, 3 imm<<12
- imm  out  WordSize  decoded immediate
- branch_addr  out  WordSize  branch/jump target
- branch_taken  out  1  predicted/forced taken
- rdn  out  5  destination register, 0 when none
- pc  out  WordSize  pass-through of pc_in
- mem_read  out  1  issuing a load
- illegal  out  1  one-cycle pulse, unknown opcode consumed
- stall_count  out  16  saturating count of load-use bubbles

Behaviour:
- Clock clk; reset rstn is asynchronous and active-low.
- Decode is combinational from instr/pc_in.
- Hazard tracker (ld_rd[4:0], ld_v), FSM state and stall_count are registered.
- Bubble encoding:
  - rdn=0, a_sel=3, b_sel=1, imm=0, branch_taken=0, mem_read=0, illegal=0.
  - branch_addr=0; pc passes through.
- Reset (rstn low):
  - FSM=RUN, ld_v=0, ld_rd=0, stall_count=0.
  - Outputs forced to bubble, instr_ready=0.
- Decode per opcode:
  - OP (R-type): a=0, b=0, rdn=rd.
  - OP-IMM / LOAD: a=0, b=1, I-imm sign-extended, rdn=rd. LOAD also sets mem_read=1.
  - STORE: a=0, b=1, S-imm, rdn=0.
  - LUI: a=3, b=3, imm=zero-extended instr[31:12], rdn=rd.
  - AUIPC: a=1, b=3, imm as for LUI, rdn=rd.
  - JAL: a=1, b=2, branch_taken=1, branch_addr=pc_in+J-imm, rdn=rd.
  - JALR: a=1, b=2, branch_taken=1, branch_addr=(rs1d+I-imm) with bit0 cleared, rdn=rd.
  - BRANCH: a=0, b=0, rdn=0, branch_addr=pc_in+B-imm, branch_taken per Optional Feature.
  - Any other opcode: bubble, illegal=1, instr consumed.
- Arithmetic: all adds modulo 2^WordSize; immediates sign-extended to WordSize.
- Source usage:
  - rs1 used by OP, OP-IMM, LOAD, STORE, JALR, BRANCH.
  - rs2 used by OP, STORE, BRANCH.
- Hazard: hazard = instr_valid & ld_v & ld_rd!=0 & (used rs1==ld_rd or used rs2==ld_rd).
- FSM states RUN and STALL:
  - RUN, hazard & !flush: output bubble, instr_ready=0, stall_count++ (saturates at 0xFFFF), ld_v<=0, ->STALL.
  - STALL: upstream holds instr stable; issue normally (hazard cannot recur since ld_v=0), ->RUN.
- Issue cycle (instr_valid & no hazard & !flush):
  - Decoded outputs driven, instr_ready=1.
  - Tracker update: ld_v<=mem_read & rd!=0, ld_rd<=rd.
- Idle (instr_valid=0): bubble, instr_ready=1, ld_v<=0.
- flush=1:
  - Highest priority, any state: bubble, instr_ready=1 (incoming instr dropped).
  - ld_v<=0, FSM->RUN, no stall_count increment, no illegal pulse.
- Reset mid-stall: returns to RUN with tracker cleared; no pending bubble survives.

Optional Feature:
- Macro ID_BTFN_PREDICT_EN.
- Defined: conditional BRANCH sets branch_taken = B-imm sign bit (backward taken, forward not taken).
- Undefined: conditional BRANCH always branch_taken=0.
- JAL/JALR are taken in both builds; branch_addr is identical in both builds.

Test Plan:
- Reset then ADDI x5,x0,7 at pc=0x100 -> a_sel=0, b_sel=1, imm=7, rdn=5, instr_ready=1, pc=0x100.
- LW x3,0(x1) then ADD x4,x3,x2 -> second cycle bubble (rdn=0, a_sel=3), instr_ready=0, stall_count=1. Next cycle ADD issues: rdn=4, a_sel=0, b_sel=0.
- LW x0 then ADD x4,x0,x0, and LW x3 then LUI x3 -> no bubble, stall_count unchanged.
- LUI x7,0xABCDE and JAL x1,-8 at pc=0x200:
  - LUI: a_sel=3, b_sel=3, imm=0x000ABCDE.
  - JAL: a_sel=1, b_sel=2, branch_taken=1, branch_addr=0x1F8, rdn=1.
- BEQ offset -16 at pc=0x300 -> branch_addr=0x2F0; branch_taken=1 with ID_BTFN_PREDICT_EN, 0 without. Offset +16 -> taken=0 in both builds.
- flush=1 during STALL and opcode 0x7F -> bubble, instr_ready=1, FSM RUN, no illegal pulse. Opcode 0x7F with flush=0 -> illegal=1 for one cycle.
